inst_fetch_ctrl: RTL
====================

// Module: inst_fetch_ctrl
// PURPOSE
//   Fetch sequencer that owns the instruction-memory address port. It keeps the fetch PC and
//   issues word reads with a fixed MEM_LAT, buffering returned words and their PCs in a prefetch
//   FIFO. IF/ID takes instructions over a valid/ready handshake. Branch redirects flush the FIFO
//   and discard stale in-flight reads.
// PARAMETERS
//   ADDR_W      32  fetch address width
//   DATA_W      32  instruction width
//   FIFO_DEPTH  4   prefetch entries; power of 2, >=2
//   MEM_LAT     1   cycles from mem_req to mem_rvalid; fixed, >=1
//   RESET_PC    0   first fetch address after reset
// PORTS
//   clk           in   1       clock, rising edge
//   rst           in   1       asynchronous, active-low reset
//   freeze        in   1       1 = issue no new reads; in-flight reads still complete
//   branch_taken  in   1       redirect request, one-cycle pulse
//   branch_addr   in   ADDR_W  redirect target; bits[1:0] forced to 0
//   mem_req       out  1       read strobe to instruction memory
//   mem_addr      out  ADDR_W  read word address (byte address, word aligned)
//   mem_rvalid    in   1       read data valid, exactly MEM_LAT cycles after mem_req
//   mem_rdata     in   DATA_W  read data
//   if_valid      out  1       FIFO head valid
//   if_ready      in   1       consumer accepts head
//   if_instr      out  DATA_W  head instruction
//   if_pc         out  ADDR_W  head instruction address
// BEHAVIOUR
//   Reset (rst=0): fetch_pc=RESET_PC, FIFO empty, inflight=0, drop=0, state=IDLE.
//     All outputs are 0 during reset except mem_addr=RESET_PC.
//   FSM
//     IDLE -> RUN on the first clock after reset release.
//     RUN -> FLUSH on branch_taken when inflight!=0 (excluding responses arriving this cycle).
//     FLUSH -> RUN when drop reaches 0.
//   Issue rule, RUN only: mem_req = !freeze && !branch_taken && (count+inflight < FIFO_DEPTH).
//     Credit-based: a response always has a free slot.
//     Each issue sends mem_addr=fetch_pc, then fetch_pc += 4 (wraps modulo 2^ADDR_W).
//   inflight: +1 per issue, -1 per mem_rvalid; same cycle = unchanged.
//   Response: if drop>0, discard the word and drop -= 1. Otherwise push {pc, rdata}, where pc is
//     taken from a MEM_LAT-deep address shift register paired with mem_req.
//   Handshake: pop when if_valid && if_ready. if_valid, if_instr and if_pc come from registered
//     FIFO state. Earliest fetch-to-if_valid latency is MEM_LAT+1 cycles.
//   Branch: FIFO count -> 0 next cycle; a pop in the same cycle counts as consumed.
//     fetch_pc <= {branch_addr[ADDR_W-1:2], 2'b00}; drop <= inflight minus any response this cycle.
//     No issue in the branch cycle; issue resumes the cycle after drop reaches 0.
//     branch_taken in FLUSH retargets fetch_pc only (drop keeps counting).
//   FIFO: push and pop in the same cycle keeps count. Pop when empty and push when full
//     cannot occur; assert in simulation.
//   freeze: holds fetch_pc. The FIFO still fills from in-flight reads and still drains.
//   Reset mid-operation: immediate return to reset state; late mem_rvalid after release is ignored
//     because inflight=0 (drop assert guards underflow).
// CONFIGURATION
//   FETCH_PERF_EN defined: adds outputs perf_fetched[31:0] and perf_dropped[31:0].
//     perf_fetched counts pushes; perf_dropped counts discarded responses plus FIFO entries flushed.
//     Both are cleared by reset and saturate at 2^32-1.
//   FETCH_PERF_EN undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//   Package fetch_pkg: FSM state encoding (IDLE/RUN/FLUSH), WORD_BYTES=4, and a fetch_entry_t
//     struct {pc, instr}.
//   Sub-module fetch_fifo: synchronous FIFO with FIFO_DEPTH entries of fetch_entry_t.
//     Ports: push, pop, flush, count, full/empty; registered head.
//   The top level holds the FSM, fetch_pc, inflight/drop counters and the address shift register.
// TESTING
//   1 Reset release, MEM_LAT=1, memory returns addr as data, if_ready=1: mem_addr 0,4,8,...;
//     first if_valid at cycle 2 with if_pc=0, then one instruction per cycle.
//   2 if_ready=0: exactly FIFO_DEPTH=4 reads issued (0..12), then mem_req=0. Raising if_ready
//     drains pcs 0,4,8,12 in order and issue resumes at 16.
//   3 MEM_LAT=3, branch_taken to 0x100 with 2 reads in flight: both responses dropped, state=FLUSH,
//     next if_pc=0x100, no stale pc delivered.
//   4 branch_addr=0x103: redirect fetches 0x100. Fetch from 0xFFFFFFFC wraps to 0x0.
//   5 freeze=1 for 5 cycles mid-stream: no mem_req; FIFO keeps draining; fetch_pc resumes unchanged.
//   6 rst=0 asserted with 2 reads in flight (MEM_LAT=3), rst=1 before their mem_rvalid: late
//     responses ignored; first if_pc=RESET_PC. With FETCH_PERF_EN, counters read 0 after reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding, entry layout and helpers.
package fetch_pkg;

  localparam int unsigned WORD_BYTES   = 4;
  localparam int unsigned ENTRY_ADDR_W = 32;
  localparam int unsigned ENTRY_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] pc;
    logic [ENTRY_DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_chk.sv
// Simulation checks on the fetch sequencer's FIFO and drop bookkeeping.
module fetch_chk #(
  parameter int unsigned CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             pop,
  input logic             full,
  input logic             empty,
  input logic             discard,
  input logic [CNT_W-1:0] drop
);

  a_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));
  a_pop_when_empty: assert property (@(posedge clk) disable iff (!rst) !(pop && empty));
  a_drop_underflow: assert property (@(posedge clk) disable iff (!rst) !(discard && (drop == CNT_W'(0))));

endmodule

// File: rtl/fetch_fifo.sv
// Prefetch queue of fetch_entry_t with occupancy count and a head read straight from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Storage, pointers and occupancy; a flush empties the queue and wins over a coincident push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_r    <= '{default: '0};
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == CNT_W'(0));
  assign full  = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: credit-limited reads, prefetch FIFO, branch flush of stale reads.
// Optional FETCH_PERF_EN adds saturating fetched/dropped performance counters.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       MEM_LAT    = 1,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped,
`endif
  output logic [ADDR_W-1:0] if_pc
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SR_W  = MEM_LAT * ADDR_W;

  fetch_state_e      state_r, state_nxt_s;
  logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_nxt_s;
  logic [CNT_W-1:0]  inflight_r, inflight_nxt_s;
  logic [CNT_W-1:0]  drop_r, drop_nxt_s;
  logic [CNT_W-1:0]  inflight_left_s, fifo_count_s;
  logic [SR_W-1:0]   addr_sr_r;
  logic              resp_s, discard_s, push_s, pop_s, issue_s;
  logic              fifo_full_s, fifo_empty_s;
  fetch_entry_t      push_entry_s, head_s;

  // Responses only count while reads are outstanding, so stale returns after reset vanish.
  assign resp_s          = mem_rvalid && (inflight_r != CNT_W'(0));
  assign discard_s       = resp_s && (drop_r != CNT_W'(0));
  assign push_s          = resp_s && !discard_s;
  assign pop_s           = if_valid && if_ready;
  assign inflight_left_s = inflight_r - CNT_W'(resp_s);
  assign issue_s         = (state_r == ST_RUN) && !freeze && !branch_taken &&
                           (({1'b0, fifo_count_s} + {1'b0, inflight_r}) < (CNT_W+1)'(FIFO_DEPTH));

  // Next state, next fetch PC and outstanding/drop bookkeeping.
  always_comb begin
    state_nxt_s    = state_r;
    fetch_pc_nxt_s = fetch_pc_r;
    inflight_nxt_s = inflight_r;
    drop_nxt_s     = drop_r;
    case ({issue_s, resp_s})
      2'b10:   inflight_nxt_s = inflight_r + CNT_W'(1);
      2'b01:   inflight_nxt_s = inflight_r - CNT_W'(1);
      default: inflight_nxt_s = inflight_r;
    endcase
    if (branch_taken) begin
      fetch_pc_nxt_s = {branch_addr[ADDR_W-1:2], 2'b00};
    end else if (issue_s) begin
      fetch_pc_nxt_s = fetch_pc_r + ADDR_W'(WORD_BYTES);
    end else begin
      fetch_pc_nxt_s = fetch_pc_r;
    end
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_RUN;
        drop_nxt_s  = drop_r;
      end
      ST_RUN: begin
        if (branch_taken && (inflight_left_s != CNT_W'(0))) begin
          state_nxt_s = ST_FLUSH;
          drop_nxt_s  = inflight_left_s;
        end else begin
          state_nxt_s = ST_RUN;
          drop_nxt_s  = drop_r;
        end
      end
      ST_FLUSH: begin
        drop_nxt_s = drop_r - CNT_W'(discard_s);
        if (drop_nxt_s == CNT_W'(0)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        drop_nxt_s  = CNT_W'(0);
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      inflight_r <= '0;
      drop_r     <= '0;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      inflight_r <= inflight_nxt_s;
      drop_r     <= drop_nxt_s;
    end
  end

  // Request addresses delayed by the memory latency so each response finds its own PC on top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_sr_r <= '0;
    end else begin
      addr_sr_r <= (addr_sr_r << ADDR_W) | SR_W'(fetch_pc_r);
    end
  end

  assign push_entry_s = '{pc: addr_sr_r[SR_W-1 -: ADDR_W], instr: mem_rdata};

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .push_data(push_entry_s),
    .pop      (pop_s),
    .flush    (branch_taken),
    .head     (head_s),
    .count    (fifo_count_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  fetch_chk #(
    .CNT_W(CNT_W)
  ) u_chk (
    .clk    (clk),
    .rst    (rst),
    .push   (push_s),
    .pop    (pop_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .discard(discard_s),
    .drop   (drop_r)
  );

  assign mem_req  = issue_s;
  assign mem_addr = fetch_pc_r;
  assign if_valid = !fifo_empty_s;
  assign if_instr = head_s.instr;
  assign if_pc    = head_s.pc;

`ifdef FETCH_PERF_EN
  logic [31:0]  perf_fetched_r, perf_dropped_r;
  logic [CNT_W:0] flushed_s;

  // Entries lost to a redirect include a same-cycle push but not a same-cycle pop.
  assign flushed_s = branch_taken ?
                     ({1'b0, fifo_count_s} - (CNT_W+1)'(pop_s) + (CNT_W+1)'(push_s)) : (CNT_W+1)'(0);

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_r <= 32'd0;
      perf_dropped_r <= 32'd0;
    end else begin
      perf_fetched_r <= sat_add32(perf_fetched_r, 32'(push_s));
      perf_dropped_r <= sat_add32(perf_dropped_r, 32'(flushed_s) + 32'(discard_s));
    end
  end

  assign perf_fetched = perf_fetched_r;
  assign perf_dropped = perf_dropped_r;
`endif

endmodule
